mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage, reading the operand values the register file supplies for rs/rt.
- Its Hi/Lo outputs feed the write-back mux for MFHI/MFLO, which writes them into the register file.
- Busy drives the pipeline stall logic.

Parameters:
- WIDTH, 32, operand width. Hi and Lo are WIDTH bits each. An operation iterates WIDTH cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  begin an operation; sampled only in IDLE.
- Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  input  WIDTH  rs value: multiplicand or dividend.
- OperandB  input  WIDTH  rt value: multiplier or divisor.
- WriteHi  input  1  MTHI strobe.
- WriteLo  input  1  MTLO strobe.
- WriteData  input  WIDTH  data for MTHI/MTLO.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when Hi/Lo hold a new result.
- DivByZero  output  1  set with Done when a DIV/DIVU had OperandB = 0.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, priority over everything):
  - State goes to IDLE.
  - Hi = 0, Lo = 0.
  - Busy = 0, Done = 0, DivByZero = 0.
  - Iteration counter cleared.
  - Reset during RUN or FIX aborts the operation; no partial result is ever visible.
- States: IDLE, RUN, FIX.
- IDLE, Start = 1 at edge t:
  - Latch Op.
  - Latch |OperandA| and |OperandB| for signed ops, raw values for unsigned ops.
  - Record the result signs.
  - Clear the counter; go to RUN.
  - Done clears at any edge where no result completes.
- RUN: one iteration per cycle, WIDTH iterations (edges t+1 .. t+WIDTH), then go to FIX.
  - Multiply: shift-add, producing a 2*WIDTH-bit unsigned product.
  - Divide: restoring, one quotient bit per cycle.
- FIX (edge t+WIDTH+1):
  - Apply sign correction.
  - Write Hi/Lo.
  - Go to IDLE.
  - Done = 1 for exactly the following cycle.
- Busy = (state != IDLE), combinational. For WIDTH = 32, Busy is high for exactly 33 cycles after the Start edge.
- Hi/Lo hold their old values for the whole operation. They change only at the FIX edge, or on MTHI/MTLO.
- Multiply result:
  - Hi = upper WIDTH bits of the 2*WIDTH-bit product; Lo = lower WIDTH bits.
  - MULT: two's-complement signed. MULTU: unsigned.
- Divide result:
  - Lo = quotient, truncated toward zero.
  - Hi = remainder, with the sign of the dividend.
  - Overflow case DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0, no flag.
- Divide by zero (OperandB = 0, DIV or DIVU):
  - Full latency still applies.
  - Lo = all ones; Hi = original OperandA.
  - DivByZero = 1 during the Done cycle, cleared the next cycle.
- Start while Busy: ignored. No restart, no queueing.
- WriteHi/WriteLo:
  - In IDLE: write WriteData into Hi/Lo at that edge. Both may be asserted together.
  - While Busy: ignored.
  - Start = 1 in the same IDLE cycle as a write: Start wins and the write is dropped.
- Op and operand changes after the Start edge have no effect.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles; then Hi=0xFFFFFFFE, Lo=0x00000001, Done pulse 1 cycle.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivByZero=0.
- DIVU A=0x1234, B=0 -> Lo=0xFFFFFFFF, Hi=0x1234, DivByZero=1 with Done.
- Start mid-operation (second Start at cycle 10, different operands) -> ignored; first result delivered at the same cycle.
- WriteHi with WriteData=0xAAAA5555 while Busy -> Hi unchanged.
- WriteHi with WriteData=0xAAAA5555 in IDLE -> Hi=0xAAAA5555 next cycle.
- Start plus WriteLo in the same IDLE cycle -> operation starts; Lo keeps its old value until the result.
- Reset asserted at cycle 20 of a MULTU -> next cycle Hi=Lo=0, Busy=0, Done=0; no Done pulse follows.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in a final FIX cycle.
`timescale 1ns / 1ps

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} stateType;

    stateType         state, nextState;
    logic [CNT_W-1:0] iterCount;
    logic             isDiv, negResult, negRemainder, zeroDivisor;
    logic [WIDTH-1:0] savedA, operandReg, accHi, accLo;

    logic             isSigned, divFits;
    logic [WIDTH-1:0] magA, magB, divRem, fixHi, fixLo;
    logic [WIDTH:0]   mulSum, divShift;

    assign isSigned = ~Op[0];
    assign magA     = (isSigned && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    assign magB     = (isSigned && OperandB[WIDTH-1]) ? -OperandB : OperandB;

    // Multiply keeps the multiplicand in operandReg; divide keeps the divisor there.
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operandReg} : '0);
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divFits  = divShift >= {1'b0, operandReg};
    assign divRem   = WIDTH'(divFits ? divShift - {1'b0, operandReg} : divShift);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        nextState = state;
        Busy      = (state != IDLE);
        case (state)
            IDLE:    if (Start) nextState = RUN;
            RUN:     if (iterCount == LAST_COUNT) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        fixHi = accHi;
        fixLo = accLo;
        if (zeroDivisor) begin
            fixHi = savedA;
            fixLo = '1;
        end else if (isDiv) begin
            fixHi = negRemainder ? -accHi : accHi;
            fixLo = negResult ? -accLo : accLo;
        end else begin
            {fixHi, fixLo} = negResult ? -{accHi, accLo} : {accHi, accLo};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            iterCount    <= '0;
            isDiv        <= 1'b0;
            negResult    <= 1'b0;
            negRemainder <= 1'b0;
            zeroDivisor  <= 1'b0;
            savedA       <= '0;
            operandReg   <= '0;
            accHi        <= '0;
            accLo        <= '0;
            Hi           <= '0;
            Lo           <= '0;
            Done         <= 1'b0;
            DivByZero    <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        isDiv        <= Op[1];
                        operandReg   <= Op[1] ? magB : magA;
                        accLo        <= Op[1] ? magA : magB;
                        accHi        <= '0;
                        negResult    <= isSigned & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                        negRemainder <= isSigned & OperandA[WIDTH-1];
                        zeroDivisor  <= Op[1] && (OperandB == '0);
                        savedA       <= OperandA;
                        iterCount    <= '0;
                    end else begin
                        if (WriteHi) Hi <= WriteData;
                        if (WriteLo) Lo <= WriteData;
                    end
                end
                RUN: begin
                    iterCount <= iterCount + 1'b1;
                    if (isDiv) begin
                        accHi <= divRem;
                        accLo <= {accLo[WIDTH-2:0], divFits};
                    end else begin
                        {accHi, accLo} <= {mulSum, accLo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    Hi        <= fixHi;
                    Lo        <= fixLo;
                    Done      <= 1'b1;
                    DivByZero <= zeroDivisor;
                end
                default: ;
            endcase
        end
    end

endmodule
